// File: rtl/ft245_axi_arb.sv
// Two-requester AXI4 arbiter: the FT245 host bridge (inport0) and the capture DMA (inport1)
// share one master port. Write and read paths each hold a round-robin grant until the response completes.
module ft245_axi_arb (
  input  logic        clk_i,
  input  logic        rst_i,
  // requester 0
  input  logic        inport0_awvalid_i,
  input  logic [31:0] inport0_awaddr_i,
  input  logic [3:0]  inport0_awid_i,
  input  logic [7:0]  inport0_awlen_i,
  input  logic [1:0]  inport0_awburst_i,
  output logic        inport0_awready_o,
  input  logic        inport0_wvalid_i,
  input  logic [31:0] inport0_wdata_i,
  input  logic [3:0]  inport0_wstrb_i,
  input  logic        inport0_wlast_i,
  output logic        inport0_wready_o,
  input  logic        inport0_bready_i,
  output logic        inport0_bvalid_o,
  output logic [1:0]  inport0_bresp_o,
  output logic [3:0]  inport0_bid_o,
  input  logic        inport0_arvalid_i,
  input  logic [31:0] inport0_araddr_i,
  input  logic [3:0]  inport0_arid_i,
  input  logic [7:0]  inport0_arlen_i,
  input  logic [1:0]  inport0_arburst_i,
  output logic        inport0_arready_o,
  input  logic        inport0_rready_i,
  output logic        inport0_rvalid_o,
  output logic [31:0] inport0_rdata_o,
  output logic [1:0]  inport0_rresp_o,
  output logic [3:0]  inport0_rid_o,
  output logic        inport0_rlast_o,
  // requester 1
  input  logic        inport1_awvalid_i,
  input  logic [31:0] inport1_awaddr_i,
  input  logic [3:0]  inport1_awid_i,
  input  logic [7:0]  inport1_awlen_i,
  input  logic [1:0]  inport1_awburst_i,
  output logic        inport1_awready_o,
  input  logic        inport1_wvalid_i,
  input  logic [31:0] inport1_wdata_i,
  input  logic [3:0]  inport1_wstrb_i,
  input  logic        inport1_wlast_i,
  output logic        inport1_wready_o,
  input  logic        inport1_bready_i,
  output logic        inport1_bvalid_o,
  output logic [1:0]  inport1_bresp_o,
  output logic [3:0]  inport1_bid_o,
  input  logic        inport1_arvalid_i,
  input  logic [31:0] inport1_araddr_i,
  input  logic [3:0]  inport1_arid_i,
  input  logic [7:0]  inport1_arlen_i,
  input  logic [1:0]  inport1_arburst_i,
  output logic        inport1_arready_o,
  input  logic        inport1_rready_i,
  output logic        inport1_rvalid_o,
  output logic [31:0] inport1_rdata_o,
  output logic [1:0]  inport1_rresp_o,
  output logic [3:0]  inport1_rid_o,
  output logic        inport1_rlast_o,
  // shared master port
  output logic        outport_awvalid_o,
  output logic [31:0] outport_awaddr_o,
  output logic [3:0]  outport_awid_o,
  output logic [7:0]  outport_awlen_o,
  output logic [1:0]  outport_awburst_o,
  input  logic        outport_awready_i,
  output logic        outport_wvalid_o,
  output logic [31:0] outport_wdata_o,
  output logic [3:0]  outport_wstrb_o,
  output logic        outport_wlast_o,
  input  logic        outport_wready_i,
  input  logic        outport_bvalid_i,
  input  logic [1:0]  outport_bresp_i,
  input  logic [3:0]  outport_bid_i,
  output logic        outport_bready_o,
  output logic        outport_arvalid_o,
  output logic [31:0] outport_araddr_o,
  output logic [3:0]  outport_arid_o,
  output logic [7:0]  outport_arlen_o,
  output logic [1:0]  outport_arburst_o,
  input  logic        outport_arready_i,
  input  logic        outport_rvalid_i,
  input  logic [31:0] outport_rdata_i,
  input  logic [1:0]  outport_rresp_i,
  input  logic [3:0]  outport_rid_i,
  input  logic        outport_rlast_i,
  output logic        outport_rready_o
);

  typedef enum logic [1:0] {WR_IDLE, WR_ACTIVE, WR_RESP} wr_state_t;
  typedef enum logic [1:0] {RD_IDLE, RD_ADDR, RD_DATA} rd_state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  id;
    logic [7:0]  len;
    logic [1:0]  burst;
  } ax_req_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
  } w_req_t;

  logic [1:0]    awvalid, wvalid, bready, arvalid, rready;
  logic [1:0]    awready, wready, bvalid, arready, rvalid;
  ax_req_t [1:0] aw_req, ar_req;
  w_req_t  [1:0] w_req;

  assign awvalid   = {inport1_awvalid_i, inport0_awvalid_i};
  assign wvalid    = {inport1_wvalid_i,  inport0_wvalid_i};
  assign bready    = {inport1_bready_i,  inport0_bready_i};
  assign arvalid   = {inport1_arvalid_i, inport0_arvalid_i};
  assign rready    = {inport1_rready_i,  inport0_rready_i};
  assign aw_req[0] = {inport0_awaddr_i, inport0_awid_i, inport0_awlen_i, inport0_awburst_i};
  assign aw_req[1] = {inport1_awaddr_i, inport1_awid_i, inport1_awlen_i, inport1_awburst_i};
  assign ar_req[0] = {inport0_araddr_i, inport0_arid_i, inport0_arlen_i, inport0_arburst_i};
  assign ar_req[1] = {inport1_araddr_i, inport1_arid_i, inport1_arlen_i, inport1_arburst_i};
  assign w_req[0]  = {inport0_wdata_i, inport0_wstrb_i, inport0_wlast_i};
  assign w_req[1]  = {inport1_wdata_i, inport1_wstrb_i, inport1_wlast_i};

  // On a tie the port that did not win last time goes next.
  function automatic logic rr_pick(input logic [1:0] req, input logic last);
    return (&req) ? ~last : req[1];
  endfunction

  // ---------------- write path ----------------
  wr_state_t wr_state_q;
  logic      wr_gnt_q, wr_last_q, aw_done_q, w_done_q;
  logic      wr_act, wr_rsp, wr_sel, wr_win;
  logic      aw_hs, w_last_hs, aw_done, w_done, b_hs;

  assign wr_act = (wr_state_q == WR_ACTIVE);
  assign wr_rsp = (wr_state_q == WR_RESP);
  assign wr_sel = (wr_state_q == WR_IDLE) ? 1'b0 : wr_gnt_q;
  assign wr_win = rr_pick(awvalid, wr_last_q);

  assign outport_awvalid_o = wr_act & awvalid[wr_gnt_q] & ~aw_done_q;
  assign outport_wvalid_o  = wr_act & wvalid[wr_gnt_q] & ~w_done_q;
  assign outport_bready_o  = wr_rsp & bready[wr_gnt_q];
  assign {outport_awaddr_o, outport_awid_o, outport_awlen_o, outport_awburst_o} = aw_req[wr_sel];
  assign {outport_wdata_o, outport_wstrb_o, outport_wlast_o} = w_req[wr_sel];

  assign aw_hs     = outport_awvalid_o & outport_awready_i;
  assign w_last_hs = outport_wvalid_o & outport_wready_i & outport_wlast_o;
  assign aw_done   = aw_done_q | aw_hs;
  assign w_done    = w_done_q | w_last_hs;
  assign b_hs      = outport_bvalid_i & outport_bready_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_state_q <= WR_IDLE;
      wr_gnt_q   <= 1'b0;
      wr_last_q  <= 1'b1;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
    end else begin
      case (wr_state_q)
        WR_IDLE: if (|awvalid) begin
          wr_state_q <= WR_ACTIVE;
          wr_gnt_q   <= wr_win;
          wr_last_q  <= wr_win;
          aw_done_q  <= 1'b0;
          w_done_q   <= 1'b0;
        end
        // W may complete before, with, or after AW; leave once both halves are in
        WR_ACTIVE: begin
          aw_done_q <= aw_done;
          w_done_q  <= w_done;
          if (aw_done && w_done) wr_state_q <= WR_RESP;
        end
        WR_RESP: if (b_hs) wr_state_q <= WR_IDLE;
        default: wr_state_q <= WR_IDLE;
      endcase
    end
  end

  // ---------------- read path ----------------
  rd_state_t rd_state_q;
  logic      rd_gnt_q, rd_last_q;
  logic      rd_addr, rd_data, rd_sel, rd_win, ar_hs, r_last_hs;

  assign rd_addr = (rd_state_q == RD_ADDR);
  assign rd_data = (rd_state_q == RD_DATA);
  assign rd_sel  = (rd_state_q == RD_IDLE) ? 1'b0 : rd_gnt_q;
  assign rd_win  = rr_pick(arvalid, rd_last_q);

  assign outport_arvalid_o = rd_addr & arvalid[rd_gnt_q];
  assign outport_rready_o  = rd_data & rready[rd_gnt_q];
  assign {outport_araddr_o, outport_arid_o, outport_arlen_o, outport_arburst_o} = ar_req[rd_sel];

  assign ar_hs     = outport_arvalid_o & outport_arready_i;
  assign r_last_hs = outport_rvalid_i & outport_rready_o & outport_rlast_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_state_q <= RD_IDLE;
      rd_gnt_q   <= 1'b0;
      rd_last_q  <= 1'b1;
    end else begin
      case (rd_state_q)
        RD_IDLE: if (|arvalid) begin
          rd_state_q <= RD_ADDR;
          rd_gnt_q   <= rd_win;
          rd_last_q  <= rd_win;
        end
        RD_ADDR: if (ar_hs) rd_state_q <= RD_DATA;
        RD_DATA: if (r_last_hs) rd_state_q <= RD_IDLE;
        default: rd_state_q <= RD_IDLE;
      endcase
    end
  end

  // ---------------- per-port handshake fan-out ----------------
  for (genvar i = 0; i < 2; i++) begin : g_port
    localparam logic P = (i == 1);
    assign awready[i] = wr_act & (wr_gnt_q == P) & ~aw_done_q & outport_awready_i;
    assign wready[i]  = wr_act & (wr_gnt_q == P) & ~w_done_q & outport_wready_i;
    assign bvalid[i]  = wr_rsp & (wr_gnt_q == P) & outport_bvalid_i;
    assign arready[i] = rd_addr & (rd_gnt_q == P) & outport_arready_i;
    assign rvalid[i]  = rd_data & (rd_gnt_q == P) & outport_rvalid_i;
  end

  assign inport0_awready_o = awready[0];
  assign inport1_awready_o = awready[1];
  assign inport0_wready_o  = wready[0];
  assign inport1_wready_o  = wready[1];
  assign inport0_bvalid_o  = bvalid[0];
  assign inport1_bvalid_o  = bvalid[1];
  assign inport0_arready_o = arready[0];
  assign inport1_arready_o = arready[1];
  assign inport0_rvalid_o  = rvalid[0];
  assign inport1_rvalid_o  = rvalid[1];

  // Response payloads go to both ports unchanged; only valid is steered.
  assign inport0_bresp_o = outport_bresp_i;
  assign inport1_bresp_o = outport_bresp_i;
  assign inport0_bid_o   = outport_bid_i;
  assign inport1_bid_o   = outport_bid_i;
  assign inport0_rdata_o = outport_rdata_i;
  assign inport1_rdata_o = outport_rdata_i;
  assign inport0_rresp_o = outport_rresp_i;
  assign inport1_rresp_o = outport_rresp_i;
  assign inport0_rid_o   = outport_rid_i;
  assign inport1_rid_o   = outport_rid_i;
  assign inport0_rlast_o = outport_rlast_i;
  assign inport1_rlast_o = outport_rlast_i;

endmodule

// File: tb/tb_ft245_axi_arb.sv
// Directed bench for ft245_axi_arb: tie alternation, W-before-AW, concurrent paths,
// backpressure and async reset during a read burst.
module tb_ft245_axi_arb;

  logic clk_i = 1'b0;
  logic rst_i;
  always #5 clk_i = ~clk_i;

  logic [1:0]       awvalid, wvalid, wlast, bready, arvalid, rready;
  logic [1:0][31:0] awaddr, wdata, araddr;
  logic [1:0][3:0]  awid, wstrb, arid;
  logic [1:0][7:0]  awlen, arlen;
  logic [1:0][1:0]  awburst, arburst;
  wire  [1:0]       awready_o, wready_o, bvalid_o, arready_o, rvalid_o, rlast_o;
  wire  [1:0][1:0]  bresp_o, rresp_o;
  wire  [1:0][3:0]  bid_o, rid_o;
  wire  [1:0][31:0] rdata_o;

  logic        outport_awready_i, outport_wready_i, outport_bvalid_i, outport_arready_i;
  logic        outport_rvalid_i, outport_rlast_i;
  logic [1:0]  outport_bresp_i, outport_rresp_i;
  logic [3:0]  outport_bid_i, outport_rid_i;
  logic [31:0] outport_rdata_i;
  wire         outport_awvalid_o, outport_wvalid_o, outport_wlast_o, outport_bready_o;
  wire         outport_arvalid_o, outport_rready_o;
  wire  [31:0] outport_awaddr_o, outport_wdata_o, outport_araddr_o;
  wire  [3:0]  outport_awid_o, outport_wstrb_o, outport_arid_o;
  wire  [7:0]  outport_awlen_o, outport_arlen_o;
  wire  [1:0]  outport_awburst_o, outport_arburst_o;

  ft245_axi_arb dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .inport0_awvalid_i(awvalid[0]), .inport0_awaddr_i(awaddr[0]), .inport0_awid_i(awid[0]),
    .inport0_awlen_i(awlen[0]), .inport0_awburst_i(awburst[0]), .inport0_awready_o(awready_o[0]),
    .inport0_wvalid_i(wvalid[0]), .inport0_wdata_i(wdata[0]), .inport0_wstrb_i(wstrb[0]),
    .inport0_wlast_i(wlast[0]), .inport0_wready_o(wready_o[0]),
    .inport0_bready_i(bready[0]), .inport0_bvalid_o(bvalid_o[0]), .inport0_bresp_o(bresp_o[0]),
    .inport0_bid_o(bid_o[0]),
    .inport0_arvalid_i(arvalid[0]), .inport0_araddr_i(araddr[0]), .inport0_arid_i(arid[0]),
    .inport0_arlen_i(arlen[0]), .inport0_arburst_i(arburst[0]), .inport0_arready_o(arready_o[0]),
    .inport0_rready_i(rready[0]), .inport0_rvalid_o(rvalid_o[0]), .inport0_rdata_o(rdata_o[0]),
    .inport0_rresp_o(rresp_o[0]), .inport0_rid_o(rid_o[0]), .inport0_rlast_o(rlast_o[0]),
    .inport1_awvalid_i(awvalid[1]), .inport1_awaddr_i(awaddr[1]), .inport1_awid_i(awid[1]),
    .inport1_awlen_i(awlen[1]), .inport1_awburst_i(awburst[1]), .inport1_awready_o(awready_o[1]),
    .inport1_wvalid_i(wvalid[1]), .inport1_wdata_i(wdata[1]), .inport1_wstrb_i(wstrb[1]),
    .inport1_wlast_i(wlast[1]), .inport1_wready_o(wready_o[1]),
    .inport1_bready_i(bready[1]), .inport1_bvalid_o(bvalid_o[1]), .inport1_bresp_o(bresp_o[1]),
    .inport1_bid_o(bid_o[1]),
    .inport1_arvalid_i(arvalid[1]), .inport1_araddr_i(araddr[1]), .inport1_arid_i(arid[1]),
    .inport1_arlen_i(arlen[1]), .inport1_arburst_i(arburst[1]), .inport1_arready_o(arready_o[1]),
    .inport1_rready_i(rready[1]), .inport1_rvalid_o(rvalid_o[1]), .inport1_rdata_o(rdata_o[1]),
    .inport1_rresp_o(rresp_o[1]), .inport1_rid_o(rid_o[1]), .inport1_rlast_o(rlast_o[1]),
    .outport_awvalid_o(outport_awvalid_o), .outport_awaddr_o(outport_awaddr_o),
    .outport_awid_o(outport_awid_o), .outport_awlen_o(outport_awlen_o),
    .outport_awburst_o(outport_awburst_o), .outport_awready_i(outport_awready_i),
    .outport_wvalid_o(outport_wvalid_o), .outport_wdata_o(outport_wdata_o),
    .outport_wstrb_o(outport_wstrb_o), .outport_wlast_o(outport_wlast_o),
    .outport_wready_i(outport_wready_i),
    .outport_bvalid_i(outport_bvalid_i), .outport_bresp_i(outport_bresp_i),
    .outport_bid_i(outport_bid_i), .outport_bready_o(outport_bready_o),
    .outport_arvalid_o(outport_arvalid_o), .outport_araddr_o(outport_araddr_o),
    .outport_arid_o(outport_arid_o), .outport_arlen_o(outport_arlen_o),
    .outport_arburst_o(outport_arburst_o), .outport_arready_i(outport_arready_i),
    .outport_rvalid_i(outport_rvalid_i), .outport_rdata_i(outport_rdata_i),
    .outport_rresp_i(outport_rresp_i), .outport_rid_i(outport_rid_i),
    .outport_rlast_i(outport_rlast_i), .outport_rready_o(outport_rready_o)
  );

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  // Entered in the first WR_ACTIVE cycle for port p; returns in the idle cycle after B.
  task automatic serve_write(input int p, input logic [31:0] addr, input int nb);
    chk("aw_vld", outport_awvalid_o, 1);
    chk("aw_addr", outport_awaddr_o, addr);
    chk("aw_len", outport_awlen_o, awlen[p]);
    chk("aw_id", outport_awid_o, awid[p]);
    chk("aw_rdy_gnt", awready_o[p], 1);
    chk("aw_rdy_other", awready_o[1-p], 0);
    for (int b = 0; b < nb; b++) begin
      wvalid[p] = 1'b1; wdata[p] = addr + 32'(b); wstrb[p] = 4'hF; wlast[p] = (b == nb - 1);
      #1;
      chk("w_data", outport_wdata_o, addr + 32'(b));
      chk("w_strb", outport_wstrb_o, 4'hF);
      chk("w_rdy_other", wready_o[1-p], 0);
      cyc();
      awvalid[p] = 1'b0;
    end
    wvalid[p] = 1'b0; wlast[p] = 1'b0;
    outport_bvalid_i = 1'b1; outport_bid_i = awid[p]; outport_bresp_i = 2'b00; bready[p] = 1'b1;
    #1;
    chk("b_vld_gnt", bvalid_o[p], 1);
    chk("b_vld_other", bvalid_o[1-p], 0);
    chk("b_rdy", outport_bready_o, 1);
    chk("b_id", bid_o[p], awid[p]);
    cyc();
    outport_bvalid_i = 1'b0; bready[p] = 1'b0;
  endtask

  int beat;

  initial begin
    rst_i = 1'b1;
    awvalid = '0; wvalid = '0; wlast = '0; bready = '0; arvalid = '0; rready = '0;
    awaddr = '0; wdata = '0; araddr = '0; awid = '0; wstrb = '0; arid = '0;
    awlen = '0; arlen = '0; awburst = '0; arburst = '0;
    outport_awready_i = 1'b1; outport_wready_i = 1'b1; outport_arready_i = 1'b1;
    outport_bvalid_i = 1'b1; outport_rvalid_i = 1'b1; outport_rlast_i = 1'b0;
    outport_bresp_i = '0; outport_rresp_i = '0; outport_bid_i = '0; outport_rid_i = '0;
    outport_rdata_i = '0;
    awaddr[0] = 32'h100; awlen[0] = 8'd3; awid[0] = 4'h1; awburst[0] = 2'b01;
    awaddr[1] = 32'h200; awlen[1] = 8'd0; awid[1] = 4'h2; awburst[1] = 2'b01;
    awvalid = 2'b11; bready = 2'b11; rready = 2'b11;

    // reset holds everything quiet even with live requests and responses
    #7;
    chk("rst_awvld", outport_awvalid_o, 0);
    chk("rst_awrdy", awready_o, 0);
    chk("rst_brdy", outport_bready_o, 0);
    chk("rst_bvld", bvalid_o, 0);
    chk("rst_rvld", rvalid_o, 0);
    chk("rst_rrdy", outport_rready_o, 0);
    outport_bvalid_i = 1'b0; outport_rvalid_i = 1'b0; bready = '0; rready = '0;
    #5 rst_i = 1'b0;

    // write tie: port0, then port1, then a repeated tie grants port0 again
    #1 chk("tie_idle_awvld", outport_awvalid_o, 0);
    cyc();
    serve_write(0, 32'h100, 4);
    #1 chk("gap1_awvld", outport_awvalid_o, 0);
    cyc();
    serve_write(1, 32'h200, 1);
    awvalid = 2'b11;
    #1 chk("gap2_awvld", outport_awvalid_o, 0);
    cyc();
    serve_write(0, 32'h100, 4);
    #1 chk("gap3_awvld", outport_awvalid_o, 0);
    cyc();
    serve_write(1, 32'h200, 1);

    // W before AW on port1
    awaddr[1] = 32'h300; wvalid[1] = 1'b1; wdata[1] = 32'h3A; wlast[1] = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("wfirst_wvld", outport_wvalid_o, 0);
      chk("wfirst_wrdy", wready_o[1], 0);
      cyc();
    end
    awvalid[1] = 1'b1; outport_awready_i = 1'b0;
    cyc();
    chk("wfirst_fwd_w", outport_wvalid_o, 1);
    chk("wfirst_wdata", outport_wdata_o, 32'h3A);
    chk("wfirst_awvld", outport_awvalid_o, 1);
    chk("wfirst_awrdy_held", awready_o[1], 0);
    cyc();
    wvalid[1] = 1'b0; wlast[1] = 1'b0;
    outport_bvalid_i = 1'b1; outport_bresp_i = 2'b10; bready[1] = 1'b1;
    #1;
    chk("wfirst_wdone", outport_wvalid_o, 0);
    chk("wfirst_not_resp", outport_bready_o, 0);
    chk("wfirst_no_bvld", bvalid_o[1], 0);
    chk("bresp_copy", bresp_o[0], 2'b10);
    outport_awready_i = 1'b1;
    #1 chk("wfirst_awrdy", awready_o[1], 1);
    cyc();
    awvalid[1] = 1'b0;
    #1;
    chk("wfirst_bvld", bvalid_o[1], 1);
    chk("wfirst_brdy", outport_bready_o, 1);
    cyc();
    outport_bvalid_i = 1'b0; bready[1] = 1'b0; outport_bresp_i = 2'b00;

    // concurrent: port0 single-beat write, port1 8-beat read
    awaddr[0] = 32'h400; awlen[0] = 8'd0; awvalid[0] = 1'b1;
    wvalid[0] = 1'b1; wdata[0] = 32'h4A; wlast[0] = 1'b1;
    araddr[1] = 32'h500; arlen[1] = 8'd7; arid[1] = 4'h5; arburst[1] = 2'b01; arvalid[1] = 1'b1;
    cyc();
    chk("cc_awvld", outport_awvalid_o, 1);
    chk("cc_wvld", outport_wvalid_o, 1);
    chk("cc_arvld", outport_arvalid_o, 1);
    chk("cc_araddr", outport_araddr_o, 32'h500);
    chk("cc_arlen", outport_arlen_o, 8'd7);
    chk("cc_arid", outport_arid_o, 4'h5);
    chk("cc_arrdy1", arready_o[1], 1);
    chk("cc_arrdy0", arready_o[0], 0);
    cyc();
    awvalid[0] = 1'b0; wvalid[0] = 1'b0; wlast[0] = 1'b0; arvalid[1] = 1'b0;
    rready[1] = 1'b1; outport_rvalid_i = 1'b1; outport_rid_i = 4'h5;
    for (int b = 0; b < 8; b++) begin
      outport_rdata_i = 32'h500 + 32'(b); outport_rlast_i = (b == 7);
      if (b == 0) begin outport_bvalid_i = 1'b1; bready[0] = 1'b1; end
      #1;
      chk("cc_rvld1", rvalid_o[1], 1);
      chk("cc_rvld0", rvalid_o[0], 0);
      chk("cc_rdata_copy", rdata_o[0], 32'h500 + 32'(b));
      if (b == 0) chk("cc_bvld0", bvalid_o[0], 1);
      if (b == 7) chk("cc_rlast", rlast_o[1], 1);
      cyc();
      outport_bvalid_i = 1'b0; bready[0] = 1'b0;
    end
    outport_rlast_i = 1'b0;
    #1;
    chk("cc_rd_idle_rvld", rvalid_o[1], 0);
    chk("cc_rd_idle_rrdy", outport_rready_o, 0);
    chk("cc_rid", rid_o[1], 4'h5);
    chk("cc_rresp", rresp_o[1], 2'b00);
    outport_rvalid_i = 1'b0; rready[1] = 1'b0;

    // write backpressure: wready toggles, 4 beats must arrive once each in order
    awaddr[1] = 32'h800; awlen[1] = 8'd3; awvalid[1] = 1'b1;
    cyc();
    beat = 0;
    for (int c = 0; c < 16 && beat < 4; c++) begin
      outport_wready_i = c[0];
      wvalid[1] = 1'b1; wdata[1] = 32'h800 + 32'(beat); wlast[1] = (beat == 3);
      #1;
      chk("bp_wrdy", wready_o[1], c[0]);
      if (outport_wvalid_o && outport_wready_i) begin
        chk("bp_wdata", outport_wdata_o, 32'h800 + 32'(beat));
        beat++;
      end
      cyc();
      awvalid[1] = 1'b0;
    end
    wvalid[1] = 1'b0; wlast[1] = 1'b0; outport_wready_i = 1'b1;
    chk("bp_beats", beat, 4);
    outport_bvalid_i = 1'b1; bready[1] = 1'b1;
    #1 chk("bp_bvld", bvalid_o[1], 1);
    cyc();
    outport_bvalid_i = 1'b0; bready[1] = 1'b0;

    // read stall: port1 holds rready low for 5 cycles
    araddr[1] = 32'h600; arlen[1] = 8'd3; arvalid[1] = 1'b1;
    cyc();
    chk("st_araddr", outport_araddr_o, 32'h600);
    cyc();
    arvalid[1] = 1'b0;
    outport_rvalid_i = 1'b1; outport_rdata_i = 32'h600;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("st_rrdy_stall", outport_rready_o, 0);
      chk("st_rvld", rvalid_o[1], 1);
      cyc();
    end
    rready[1] = 1'b1;
    for (int b = 0; b < 4; b++) begin
      outport_rdata_i = 32'h600 + 32'(b); outport_rlast_i = (b == 3);
      #1;
      chk("st_rdata", rdata_o[1], 32'h600 + 32'(b));
      chk("st_rrdy", outport_rready_o, 1);
      cyc();
    end
    outport_rvalid_i = 1'b0; outport_rlast_i = 1'b0; rready[1] = 1'b0;
    #1 chk("st_rd_idle", outport_arvalid_o | outport_rready_o, 0);

    // async reset during beat 2 of a port0 read; the next tie must go to port0
    araddr[0] = 32'h700; arlen[0] = 8'd3; arvalid[0] = 1'b1;
    cyc();
    chk("rr_araddr", outport_araddr_o, 32'h700);
    cyc();
    arvalid[0] = 1'b0; rready[0] = 1'b1; outport_rvalid_i = 1'b1;
    for (int b = 0; b < 2; b++) begin
      outport_rdata_i = 32'h700 + 32'(b);
      cyc();
    end
    outport_rdata_i = 32'h702;
    #1 chk("rr_beat2_rvld", rvalid_o[0], 1);
    #1 rst_i = 1'b1;
    #1;
    chk("rr_rst_rvld", rvalid_o[0], 0);
    chk("rr_rst_rrdy", outport_rready_o, 0);
    outport_rvalid_i = 1'b0; rready[0] = 1'b0;
    cyc();
    rst_i = 1'b0;
    arvalid = 2'b11;
    cyc();
    chk("rr_tie_addr", outport_araddr_o, 32'h700);
    chk("rr_tie_rdy0", arready_o[0], 1);
    chk("rr_tie_rdy1", arready_o[1], 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
